// File: rtl/decode_ctrl_seq.sv
// ---------------------------------------------------------------------------
// decode_ctrl_seq
//   Registered, stall-aware decode-stage control decoder. Each accepted
//   opcode is decoded into the control bundle and held in the D->E pipeline
//   register. A MUL with MUL_LATENCY > 1 holds off further accepts while EX
//   is busy. Unknown opcodes issue a bubble, pulse 'illegal' and, when
//   TRAP_ON_ILL is set, park the decoder in TRAP until a flush.
//
// Handshake (fetch -> decode): a transfer happens on a rising edge where
//   in_valid & in_ready are both 1. in_ready is combinational:
//   reset_n & (state == RUN) & ~ex_stall & ~flush. Fetch must hold the
//   opcode stable until it is accepted. Towards EX, out_valid qualifies the
//   bundle; ex_stall=1 freezes the bundle and out_valid.
//
// Ports
//   clk, reset_n           clock (rising edge), async active-low reset
//   in_valid / in_ready    fetch handshake
//   opcode                 instruction operation code
//   ex_stall               EX back-pressure: hold the bundle
//   flush                  squash bundle, abort MUL wait, leave TRAP
//   out_valid              bundle valid for EX (0 for a bubble)
//   regwrite, branch,
//   memwrite, alusrc,
//   aluop, byteword        registered control bundle (aluop = opcode)
//   mul_busy               MUL wait in progress
//   illegal                one-cycle pulse after an unknown opcode is accepted
//   illegal_opcode         first unknown opcode since reset/flush (sticky)
//   state_dbg              FSM state (0 RUN, 1 MULW, 2 TRAP)
// ---------------------------------------------------------------------------
module decode_ctrl_seq #(
    parameter int OPCODE_W    = 8,
    parameter int MUL_LATENCY = 4,
    parameter int TRAP_ON_ILL = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                ex_stall,
    input  logic                flush,
    output logic                out_valid,
    output logic                regwrite,
    output logic                branch,
    output logic                memwrite,
    output logic                alusrc,
    output logic [OPCODE_W-1:0] aluop,
    output logic                byteword,
    output logic                mul_busy,
    output logic                illegal,
    output logic [OPCODE_W-1:0] illegal_opcode,
    output logic [1:0]          state_dbg
);

    // Opcode encodings shared with the rest of the pipeline.
    localparam logic [OPCODE_W-1:0] OPCODE_ADD  = OPCODE_W'('h00);
    localparam logic [OPCODE_W-1:0] OPCODE_SUB  = OPCODE_W'('h01);
    localparam logic [OPCODE_W-1:0] OPCODE_MOV  = OPCODE_W'('h02);
    localparam logic [OPCODE_W-1:0] OPCODE_MUL  = OPCODE_W'('h03);
    localparam logic [OPCODE_W-1:0] OPCODE_LDB  = OPCODE_W'('h04);
    localparam logic [OPCODE_W-1:0] OPCODE_LDW  = OPCODE_W'('h05);
    localparam logic [OPCODE_W-1:0] OPCODE_STB  = OPCODE_W'('h06);
    localparam logic [OPCODE_W-1:0] OPCODE_STW  = OPCODE_W'('h07);
    localparam logic [OPCODE_W-1:0] OPCODE_BEQ  = OPCODE_W'('h08);
    localparam logic [OPCODE_W-1:0] OPCODE_JUMP = OPCODE_W'('h09);
    localparam logic [OPCODE_W-1:0] OPCODE_IRET = OPCODE_W'('h0A);

    localparam int              CNT_W        = $clog2(MUL_LATENCY) + 1;
    localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LATENCY - 1);
    localparam logic            MUL_MULTI    = (MUL_LATENCY > 1);
    localparam logic            TRAP_EN      = (TRAP_ON_ILL != 0);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_MULW = 2'd1,
        ST_TRAP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] mul_cnt;
    logic             ill_held;

    // Combinational decode of the presented opcode.
    logic dec_known;
    logic dec_is_mul;
    logic [4:0] dec_bits;   // {regwrite, branch, alusrc, byteword, memwrite}

    always_comb begin
        dec_known  = 1'b1;
        dec_is_mul = 1'b0;
        dec_bits   = 5'b00000;
        case (opcode)
            OPCODE_ADD, OPCODE_SUB, OPCODE_MOV: dec_bits = 5'b10010;
            OPCODE_MUL: begin
                dec_bits   = 5'b10010;
                dec_is_mul = 1'b1;
            end
            OPCODE_LDB:                            dec_bits = 5'b10100;
            OPCODE_LDW:                            dec_bits = 5'b10110;
            OPCODE_STB:                            dec_bits = 5'b00001;
            OPCODE_STW:                            dec_bits = 5'b00011;
            OPCODE_BEQ, OPCODE_JUMP, OPCODE_IRET:  dec_bits = 5'b01110;
            default: begin
                dec_known = 1'b0;   // bubble: no enables at all
                dec_bits  = 5'b00000;
            end
        endcase
    end

    logic accept;
    logic acc_mul;
    logic acc_ill;

    assign accept  = in_valid & in_ready;
    assign acc_mul = accept & dec_is_mul & MUL_MULTI;
    assign acc_ill = accept & ~dec_known;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (acc_mul) begin
                        state_next = ST_MULW;
                    end else if (acc_ill && TRAP_EN) begin
                        state_next = ST_TRAP;
                    end
                end
                ST_MULW: begin
                    // Leave on the 1->0 step; frozen while EX stalls.
                    if (!ex_stall && mul_cnt == CNT_W'(1)) begin
                        state_next = ST_RUN;
                    end
                end
                ST_TRAP: state_next = ST_TRAP;
                default: state_next = ST_RUN;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = reset_n & (state == ST_RUN) & ~ex_stall & ~flush;
        mul_busy  = (state == ST_MULW);
        state_dbg = state;
    end

    // MUL wait counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mul_cnt <= '0;
        end else if (flush) begin
            mul_cnt <= '0;
        end else if (acc_mul) begin
            mul_cnt <= MUL_CNT_INIT;
        end else if (state == ST_MULW && !ex_stall && mul_cnt != '0) begin
            mul_cnt <= mul_cnt - CNT_W'(1);
        end
    end

    // D->E pipeline register and illegal-opcode tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid      <= 1'b0;
            regwrite       <= 1'b0;
            branch         <= 1'b0;
            alusrc         <= 1'b0;
            byteword       <= 1'b0;
            memwrite       <= 1'b0;
            aluop          <= '0;
            illegal        <= 1'b0;
            illegal_opcode <= '0;
            ill_held       <= 1'b0;
        end else if (flush) begin
            out_valid      <= 1'b0;
            regwrite       <= 1'b0;
            branch         <= 1'b0;
            alusrc         <= 1'b0;
            byteword       <= 1'b0;
            memwrite       <= 1'b0;
            aluop          <= '0;
            illegal        <= 1'b0;
            illegal_opcode <= '0;
            ill_held       <= 1'b0;
        end else begin
            illegal <= acc_ill;
            if (acc_ill && !ill_held) begin
                illegal_opcode <= opcode;
                ill_held       <= 1'b1;
            end
            if (accept) begin
                // A bubble carries aluop but is not marked valid.
                out_valid <= dec_known;
                {regwrite, branch, alusrc, byteword, memwrite} <= dec_bits;
                aluop     <= opcode;
            end else if (!ex_stall) begin
                // EX consumed the bundle; fields hold, only valid drops.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_ctrl_seq.sv
module tb_decode_ctrl_seq;

    localparam logic [7:0] OP_ADD = 8'h00;
    localparam logic [7:0] OP_MUL = 8'h03;
    localparam logic [7:0] OP_LDW = 8'h05;
    localparam logic [7:0] OP_STB = 8'h06;
    localparam logic [7:0] OP_STW = 8'h07;
    localparam logic [7:0] OP_BEQ = 8'h08;
    localparam logic [7:0] OP_BAD = 8'hFF;

    // Expected {out_valid, regwrite, branch, alusrc, byteword, memwrite}
    localparam logic [5:0] B_LDW  = 6'b1_10110;
    localparam logic [5:0] B_ADD  = 6'b1_10010;
    localparam logic [5:0] B_MUL  = 6'b1_10010;
    localparam logic [5:0] B_STB  = 6'b1_00001;
    localparam logic [5:0] B_STW  = 6'b1_00011;
    localparam logic [5:0] B_BEQ  = 6'b1_01110;
    localparam logic [5:0] B_NONE = 6'b0_00000;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       ex_stall = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] opcode = 8'h00;
    logic       in_ready, out_valid, regwrite, branch, memwrite, alusrc, byteword;
    logic       mul_busy, illegal;
    logic [7:0] aluop, illegal_opcode;
    logic [1:0] state_dbg;
    logic [5:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    assign obs = {out_valid, regwrite, branch, alusrc, byteword, memwrite};

    decode_ctrl_seq #(.OPCODE_W(8), .MUL_LATENCY(4), .TRAP_ON_ILL(1)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .ex_stall(ex_stall), .flush(flush),
        .out_valid(out_valid), .regwrite(regwrite), .branch(branch),
        .memwrite(memwrite), .alusrc(alusrc), .aluop(aluop), .byteword(byteword),
        .mul_busy(mul_busy), .illegal(illegal), .illegal_opcode(illegal_opcode),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b1; opcode = OP_LDW;
        #3;
        n_checks++;
        if ({obs, mul_busy, illegal} !== 8'h00 || aluop !== 8'h00 || illegal_opcode !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: got bundle=%b busy=%b ill=%b aluop=%h io=%h want all 0",
                     obs, mul_busy, illegal, aluop, illegal_opcode);
        end
        step();
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL release_in_ready: got %b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        n_checks++;
        if (obs !== B_LDW || aluop !== OP_LDW) begin
            n_fail++; $display("FAIL ldw_bundle: got %b/%h want %b/%h", obs, aluop, B_LDW, OP_LDW);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL ldw_valid_drop: got %b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; opcode = OP_ADD;
        step();
        n_checks++;
        if (obs !== B_ADD || aluop !== OP_ADD) begin
            n_fail++; $display("FAIL b2b_add: got %b/%h want %b/%h", obs, aluop, B_ADD, OP_ADD);
        end
        opcode = OP_STB;
        step();
        n_checks++;
        if (obs !== B_STB || aluop !== OP_STB) begin
            n_fail++; $display("FAIL b2b_stb: got %b/%h want %b/%h", obs, aluop, B_STB, OP_STB);
        end
        opcode = OP_BEQ;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (obs !== B_BEQ || aluop !== OP_BEQ) begin
            n_fail++; $display("FAIL b2b_beq: got %b/%h want %b/%h", obs, aluop, B_BEQ, OP_BEQ);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_idle: got %b want 0", out_valid);
        end
    endtask

    task automatic test_mul();
        int busy_cycles;
        int mb_cycles;
        in_valid = 1'b1; opcode = OP_MUL;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (obs !== B_MUL || aluop !== OP_MUL || mul_busy !== 1'b1) begin
            n_fail++; $display("FAIL mul_bundle: got %b/%h busy=%b want %b/%h busy=1",
                               obs, aluop, mul_busy, B_MUL, OP_MUL);
        end
        busy_cycles = 0; mb_cycles = 0;
        for (int k = 0; k < 20; k++) begin
            if (in_ready === 1'b1) break;
            busy_cycles++;
            if (mul_busy === 1'b1) mb_cycles++;
            step();
        end
        n_checks++;
        if (busy_cycles != 3 || mb_cycles != 3) begin
            n_fail++; $display("FAIL mul_wait: got ready_low=%0d busy=%0d want 3/3", busy_cycles, mb_cycles);
        end
        n_checks++;
        if (mul_busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL mul_done: got busy=%b valid=%b want 0/0", mul_busy, out_valid);
        end

        // Same again with EX stalled for two cycles in the middle of the wait.
        in_valid = 1'b1; opcode = OP_MUL;
        step();
        in_valid = 1'b0;
        busy_cycles = 0;
        for (int k = 1; k <= 20; k++) begin
            ex_stall = (k == 2 || k == 3);
            #1;
            if (in_ready === 1'b1) break;
            busy_cycles++;
            @(posedge clk);
            #1;
        end
        ex_stall = 1'b0;
        n_checks++;
        if (busy_cycles != 5) begin
            n_fail++; $display("FAIL mul_stall_wait: got ready_low=%0d want 5", busy_cycles);
        end
    endtask

    task automatic test_stall_hold();
        in_valid = 1'b1; opcode = OP_STW;
        step();
        ex_stall = 1'b1; opcode = OP_ADD;
        n_checks++;
        if (obs !== B_STW || aluop !== OP_STW) begin
            n_fail++; $display("FAIL stw_bundle: got %b/%h want %b/%h", obs, aluop, B_STW, OP_STW);
        end
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL stall_in_ready: got %b want 0", in_ready);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (obs !== B_STW || aluop !== OP_STW) begin
                n_fail++; $display("FAIL stall_hold_%0d: got %b/%h want %b/%h", k, obs, aluop, B_STW, OP_STW);
            end
        end
        ex_stall = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL unstall_in_ready: got %b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        n_checks++;
        if (obs !== B_ADD || aluop !== OP_ADD) begin
            n_fail++; $display("FAIL after_stall_add: got %b/%h want %b/%h", obs, aluop, B_ADD, OP_ADD);
        end
        step();
    endtask

    task automatic test_illegal();
        in_valid = 1'b1; opcode = OP_BAD;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (obs !== B_NONE || aluop !== OP_BAD || illegal !== 1'b1 || illegal_opcode !== OP_BAD) begin
            n_fail++; $display("FAIL ill_bubble: got %b/%h ill=%b io=%h want %b/ff ill=1 io=ff",
                               obs, aluop, illegal, illegal_opcode, B_NONE);
        end
        n_checks++;
        if (in_ready !== 1'b0 || state_dbg !== 2'd2) begin
            n_fail++; $display("FAIL ill_trap: got ready=%b state=%0d want 0/2", in_ready, state_dbg);
        end
        step();
        n_checks++;
        if (illegal !== 1'b0 || illegal_opcode !== OP_BAD) begin
            n_fail++; $display("FAIL ill_pulse: got ill=%b io=%h want 0/ff", illegal, illegal_opcode);
        end
        in_valid = 1'b1; opcode = OP_ADD;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || aluop !== OP_BAD) begin
            n_fail++; $display("FAIL trap_blocks: got valid=%b ready=%b aluop=%h want 0/0/ff",
                               out_valid, in_ready, aluop);
        end
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || illegal_opcode !== 8'h00 || state_dbg !== 2'd0 || aluop !== 8'h00) begin
            n_fail++; $display("FAIL trap_flush: got ready=%b io=%h state=%0d aluop=%h want 1/00/0/00",
                               in_ready, illegal_opcode, state_dbg, aluop);
        end
    endtask

    task automatic test_flush();
        // Flush during the MUL wait, with EX stalled (flush wins over stall).
        in_valid = 1'b1; opcode = OP_MUL;
        step();
        in_valid = 1'b0; ex_stall = 1'b1;
        step();
        n_checks++;
        if (mul_busy !== 1'b1 || obs !== B_MUL) begin
            n_fail++; $display("FAIL flush_pre: got busy=%b bundle=%b want 1/%b", mul_busy, obs, B_MUL);
        end
        flush = 1'b1; in_valid = 1'b1; opcode = OP_ADD;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_in_ready: got %b want 0", in_ready);
        end
        step();
        flush = 1'b0; in_valid = 1'b0; ex_stall = 1'b0;
        n_checks++;
        if (mul_busy !== 1'b0 || obs !== B_NONE || state_dbg !== 2'd0 || aluop !== 8'h00) begin
            n_fail++; $display("FAIL flush_mul: got busy=%b bundle=%b state=%0d aluop=%h want 0/%b/0/00",
                               mul_busy, obs, state_dbg, aluop, B_NONE);
        end
        // Flush with a presented opcode in RUN: not accepted, re-presented later.
        flush = 1'b1; in_valid = 1'b1; opcode = OP_STB;
        step();
        flush = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || aluop !== 8'h00) begin
            n_fail++; $display("FAIL flush_no_accept: got valid=%b aluop=%h want 0/00", out_valid, aluop);
        end
        step();
        in_valid = 1'b0;
        n_checks++;
        if (obs !== B_STB || aluop !== OP_STB) begin
            n_fail++; $display("FAIL flush_represent: got %b/%h want %b/%h", obs, aluop, B_STB, OP_STB);
        end
        step();
    endtask

    task automatic test_reset_mid_mul();
        in_valid = 1'b1; opcode = OP_MUL;
        step();
        in_valid = 1'b0;
        step();
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (mul_busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 || state_dbg !== 2'd0) begin
            n_fail++; $display("FAIL reset_mid_mul: got busy=%b valid=%b ready=%b state=%0d want 0/0/0/0",
                               mul_busy, out_valid, in_ready, state_dbg);
        end
        step();
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_mul_ready: got %b want 1", in_ready);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_back_to_back();
        test_mul();
        test_stall_hold();
        test_illegal();
        test_flush();
        test_reset_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
